pwm_demodulator: RTL

Receive-side counterpart to the tone generator's PWM output. The block samples an asynchronous PWM/square-wave input and measures the period and high time of each cycle in clock cycles. It reports each completed measurement with a one-cycle strobe, flags note changes, and flags silence when no edges arrive. It is used for on-chip loopback self-test of the sound path and as a pitch-capture front end for an external tone input.

---
 rtl/tinytone_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 33 +++
 rtl/pwm_demodulator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tinytone_pkg.sv
// Shared constants and FSM encoding for the tinytone sound path blocks.
package tinytone_pkg;

    // Default counter width and silence timeout shared with the strobe generator
    localparam int          DEF_BW          = 24;
    localparam logic [23:0] DEF_TIMEOUT     = 24'd2400000;
    localparam int          DEF_SYNC_STAGES = 2;

    // PWM demodulator state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,  // waiting for the first rising edge
        ST_HIGH = S_HIGH,  // rising edge seen, waiting for the falling edge
        ST_LOW  = S_LOW    // falling edge seen, waiting for the closing rising edge
    } demod_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level input with registered
// previous-level flop, giving a clean level plus single-cycle rise/fall pulses.
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw input through the synchronizer chain and remember the last level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_prev;
    assign fall  = ~level & r_prev;

endmodule

// File: rtl/pwm_demodulator.sv
// PWM demodulator: measures period (rise to rise) and high time (rise to fall)
// of a synchronized PWM input in clock cycles, strobes each completed
// measurement, flags period changes and reports silence after a timeout.
module pwm_demodulator
    import tinytone_pkg::*;
#(
    parameter int             BW          = DEF_BW,
    parameter int             SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [BW-1:0]  TIMEOUT     = BW'(DEF_TIMEOUT)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          pwm_i,
    output logic [BW-1:0] period_o,
    output logic [BW-1:0] high_o,
    output logic          valid_o,
    output logic          note_change_o,
    output logic          silent_o
);

    localparam logic [BW-1:0] CNT_ONE = BW'(1);

    // Synchronized input and edge pulses
    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pwm_i),
        .level   (w_level),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // State and datapath registers
    demod_state_t  r_state;
    logic [BW-1:0] r_cnt;
    logic [BW-1:0] r_hcnt;
    logic [BW-1:0] r_period;
    logic [BW-1:0] r_high;
    logic          r_valid;
    logic          r_note;
    logic          r_silent;

    // Next-state values
    demod_state_t  w_state_nxt;
    logic [BW-1:0] w_cnt_nxt;
    logic [BW-1:0] w_hcnt_nxt;
    logic [BW-1:0] w_period_nxt;
    logic [BW-1:0] w_high_nxt;
    logic          w_valid_nxt;
    logic          w_note_nxt;
    logic          w_silent_nxt;
    logic          w_at_timeout;

    assign w_at_timeout = (r_cnt == TIMEOUT);

    // Cycle counter: restarts at 1 on every rise so that at the next rise it
    // holds the period; it sticks at TIMEOUT so it never wraps during silence.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_rise) begin
            w_cnt_nxt = CNT_ONE;
        end else if (!w_at_timeout) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Measurement FSM: next state and next output/latch values.
    // An edge always takes priority over a coincident timeout; the timeout
    // guard therefore checks that the synchronized level has not changed.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_valid_nxt  = 1'b0;
        w_note_nxt   = 1'b0;
        w_silent_nxt = r_silent;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (w_fall) begin
                    w_hcnt_nxt  = r_cnt;
                    w_state_nxt = ST_LOW;
                end else if (w_level && w_at_timeout) begin
                    // Input stuck high
                    w_state_nxt  = ST_IDLE;
                    w_silent_nxt = 1'b1;
                    w_period_nxt = '0;
                    w_high_nxt   = '0;
                end
            end

            ST_LOW: begin
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    w_high_nxt   = r_hcnt;
                    w_valid_nxt  = 1'b1;
                    w_note_nxt   = (r_cnt != r_period);
                    w_silent_nxt = 1'b0;
                    w_state_nxt  = ST_HIGH;
                end else if (!w_level && w_at_timeout) begin
                    // Input stuck low
                    w_state_nxt  = ST_IDLE;
                    w_silent_nxt = 1'b1;
                    w_period_nxt = '0;
                    w_high_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register state, counters and outputs; reset discards any partial measurement
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hcnt   <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_note   <= 1'b0;
            r_silent <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_valid  <= w_valid_nxt;
            r_note   <= w_note_nxt;
            r_silent <= w_silent_nxt;
        end
    end

    assign period_o      = r_period;
    assign high_o        = r_high;
    assign valid_o       = r_valid;
    assign note_change_o = r_note;
    assign silent_o      = r_silent;

endmodule
